// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Load/store bus between the MIPS core (master) and the wait-state data
// memory responder (slave).
//   req_valid/req_ready   : request handshake, master -> slave
//   req_write             : 1 = store, 0 = load
//   req_addr  [ADDR_W]    : word address
//   req_wdata [32]        : store data
//   resp_valid/resp_ready : response handshake, slave -> master
//   resp_rdata [32]       : load data, 0 for stores
//   resp_err              : address error flag
interface dmem_responder_if #(
   parameter int ADDR_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Wait-state data memory for the core's load/store port. One request is
// accepted in IDLE, held for WAIT_CYCLES wait states, committed exactly once,
// and the response is held in RESP until the core takes it.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : dmem_responder_if.slave (request/response handshake)
//   busy  : registered, high while not IDLE (pipeline stall)
// Optional feature: define DMEM_RANGE_CHECK_EN to flag latched addresses
// >= DEPTH as errors (no write, zero read data, resp_err=1). Without it the
// address wraps to the low log2(DEPTH) bits and resp_err stays 0.
module dmem_responder #(
   parameter int DEPTH       = 8192,
   parameter int ADDR_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   dmem_responder_if.slave   bus,
   output logic              busy
);

   localparam int IDX_W = $clog2(DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              busy_q;

   logic [31:0]       mem [DEPTH];
   logic [IDX_W-1:0]  memIdx;
   logic              addrErr;
   logic              commitNow;

   assign memIdx    = addr_q[IDX_W-1:0];
   assign commitNow = (state_q == ST_WAIT) && (cnt_q == 8'd0);

`ifdef DMEM_RANGE_CHECK_EN
   assign addrErr = (32'(addr_q) >= 32'(DEPTH));
`else
   assign addrErr = 1'b0;
   if (ADDR_W > IDX_W) begin : g_wrap
      // High address bits are deliberately dropped so accesses wrap.
      logic unusedAddrHigh;
      assign unusedAddrHigh = ^addr_q[ADDR_W-1:IDX_W];
   end
`endif

   // Next-state logic: the read data and error flag are decided at the commit
   // edge and then frozen for the whole RESP phase.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               state_d = ST_WAIT;
               cnt_d   = 8'(WAIT_CYCLES);
            end
         end
         ST_WAIT: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_RESP;
               err_d   = addrErr;
               rdata_d = (write_q || addrErr) ? 32'h0 : mem[memIdx];
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d = ST_IDLE;
               rdata_d = 32'h0;
               err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and response registers; busy is registered from the next state
   // so it is high exactly while the current state is not IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   // Request holding registers; inputs are only looked at on the accept edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
      end else if ((state_q == ST_IDLE) && bus.req_valid) begin
         write_q <= bus.req_write;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
      end
   end

   // Storage array, never cleared; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!reset && commitNow && write_q && !addrErr) begin
         mem[memIdx] <= wdata_q;
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Three responders with 2, 0 and 4 wait states share one driver; sel picks
// which one sees the handshake. A word-level memory model (associative array)
// predicts read data and error flags for the table and random phases.
module tb_dmem_responder;

   localparam int DEPTH = 8192;

   logic        clk = 1'b0;
   logic        rst;
   int          sel;
   logic        reqValid, reqWrite, respReady;
   logic [15:0] reqAddr;
   logic [31:0] reqWdata;

   logic        selReqReady, selRespValid, selErr, selBusy;
   logic [31:0] selRdata;
   logic        busy0, busy1, busy2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_responder_if #(.ADDR_W(16)) bus0 ();
   dmem_responder_if #(.ADDR_W(16)) bus1 ();
   dmem_responder_if #(.ADDR_W(16)) bus2 ();

   assign bus0.req_valid = reqValid && (sel == 0);
   assign bus1.req_valid = reqValid && (sel == 1);
   assign bus2.req_valid = reqValid && (sel == 2);
   assign bus0.resp_ready = respReady && (sel == 0);
   assign bus1.resp_ready = respReady && (sel == 1);
   assign bus2.resp_ready = respReady && (sel == 2);
   assign bus0.req_write = reqWrite;
   assign bus1.req_write = reqWrite;
   assign bus2.req_write = reqWrite;
   assign bus0.req_addr  = reqAddr;
   assign bus1.req_addr  = reqAddr;
   assign bus2.req_addr  = reqAddr;
   assign bus0.req_wdata = reqWdata;
   assign bus1.req_wdata = reqWdata;
   assign bus2.req_wdata = reqWdata;

   dmem_responder #(.DEPTH(DEPTH), .ADDR_W(16), .WAIT_CYCLES(2)) dut0 (
      .clk(clk), .reset(rst), .bus(bus0.slave), .busy(busy0));
   dmem_responder #(.DEPTH(DEPTH), .ADDR_W(16), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .reset(rst), .bus(bus1.slave), .busy(busy1));
   dmem_responder #(.DEPTH(DEPTH), .ADDR_W(16), .WAIT_CYCLES(4)) dut2 (
      .clk(clk), .reset(rst), .bus(bus2.slave), .busy(busy2));

   // Route the selected responder's outputs to the checking logic.
   always_comb begin
      case (sel)
         1: begin
            selReqReady = bus1.req_ready; selRespValid = bus1.resp_valid;
            selRdata = bus1.resp_rdata; selErr = bus1.resp_err; selBusy = busy1;
         end
         2: begin
            selReqReady = bus2.req_ready; selRespValid = bus2.resp_valid;
            selRdata = bus2.resp_rdata; selErr = bus2.resp_err; selBusy = busy2;
         end
         default: begin
            selReqReady = bus0.req_ready; selRespValid = bus0.resp_valid;
            selRdata = bus0.resp_rdata; selErr = bus0.resp_err; selBusy = busy0;
         end
      endcase
   end

   // Behavioural memory model: one word array per responder.
   logic [31:0] refMem [int];

   function automatic int waitOf(input int s);
      return (s == 0) ? 2 : (s == 1) ? 0 : 4;
   endfunction

   function automatic int keyOf(input int s, input logic [15:0] a);
      return s * 65536 + (int'(a) % DEPTH);
   endfunction

   function automatic logic modelErr(input logic [15:0] a);
`ifdef DMEM_RANGE_CHECK_EN
      return int'(a) >= DEPTH;
`else
      return 1'b0;
`endif
   endfunction

   function automatic void modelApply(input int s, input bit wr, input logic [15:0] a,
                                      input logic [31:0] d);
      if (wr && !modelErr(a)) refMem[keyOf(s, a)] = d;
   endfunction

   typedef struct {
      int          sel;
      bit          wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          hold;
      logic [31:0] expRdata;
      logic        expErr;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(input int s, input bit wr, input logic [15:0] a,
                                  input logic [31:0] d, input int hold,
                                  input logic [31:0] er, input logic ee);
      vec_t v;
      v.sel = s; v.wr = wr; v.addr = a; v.wdata = d; v.hold = hold;
      v.expRdata = er; v.expErr = ee;
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, ".reqReady"}, 32'(selReqReady), 32'd1);
      checkOutput({tag, ".respValid"}, 32'(selRespValid), 32'd0);
      checkOutput({tag, ".rdata"}, selRdata, 32'h0);
      checkOutput({tag, ".err"}, 32'(selErr), 32'd0);
      checkOutput({tag, ".busy"}, 32'(selBusy), 32'd0);
   endtask

   // Runs one request: waits for ready, checks latency, optional back-pressure,
   // then consumes the response and checks the return to reset-like outputs.
   task automatic applyStimulus(input int s, input bit wr, input logic [15:0] a,
                                input logic [31:0] d, input int hold,
                                output logic [31:0] rd, output logic er);
      int n;
      sel = s; reqWrite = wr; reqAddr = a; reqWdata = d; reqValid = 1'b1;
      respReady = (hold == 0);
      n = 0;
      while (selReqReady !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      checkOutput("acceptReady", 32'(selReqReady), 32'd1);
      @(posedge clk); #1;
      reqValid = 1'b0; reqWrite = 1'($urandom); reqAddr = 16'($urandom); reqWdata = $urandom;
      checkOutput("busyAfterAccept", 32'(selBusy), 32'd1);
      checkOutput("readyAfterAccept", 32'(selReqReady), 32'd0);
      n = 0;
      while (selRespValid !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
      checkOutput("latency", 32'(n), 32'(waitOf(s) + 1));
      rd = selRdata; er = selErr;
      for (int i = 1; i < hold; i++) begin
         @(posedge clk); #1;
         checkOutput("holdValid", 32'(selRespValid), 32'd1);
         checkOutput("holdBusy", 32'(selBusy), 32'd1);
      end
      respReady = 1'b1;
      @(posedge clk); #1;
      respReady = 1'b0;
      checkIdleOutputs("afterConsume");
   endtask

   task automatic applyReset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      rst = 1'b1; sel = 0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0;
      reqWdata = '0; respReady = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         checkIdleOutputs("reset");
      end

      // Store/load, preloads, zero-wait back-to-back, range/wrap sequence.
      addVec(0, 1, 16'h0010, 32'hDEADBEEF, 0, 32'h0, 1'b0);
      addVec(0, 0, 16'h0010, 32'h0, 0, 32'hDEADBEEF, 1'b0);
      addVec(0, 1, 16'h0004, 32'h12345678, 0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) addVec(1, 1, 16'(i), 32'(i + 1), 0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) addVec(1, 0, 16'(i), 32'h0, 0, 32'(i + 1), 1'b0);
      addVec(2, 1, 16'h0020, 32'hAAAA5555, 1, 32'h0, 1'b0);
      addVec(0, 1, 16'h0000, 32'h00000077, 2, 32'h0, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
      addVec(0, 1, 16'h2000, 32'h1, 0, 32'h0, 1'b1);
      addVec(0, 0, 16'h2000, 32'h0, 0, 32'h0, 1'b1);
      addVec(0, 0, 16'h0000, 32'h0, 0, 32'h77, 1'b0);
`else
      addVec(0, 1, 16'h2000, 32'h1, 0, 32'h0, 1'b0);
      addVec(0, 0, 16'h2000, 32'h0, 0, 32'h1, 1'b0);
      addVec(0, 0, 16'h0000, 32'h0, 0, 32'h1, 1'b0);
`endif
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold, rd, er);
         checkOutput($sformatf("vec%0d.rdata", i), rd, vecs[i].expRdata);
         checkOutput($sformatf("vec%0d.err", i), 32'(er), 32'(vecs[i].expErr));
         modelApply(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      end

      // Back-pressure on a load while the next request waits for ready.
      sel = 0; reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 16'h0004; respReady = 1'b0;
      @(posedge clk); #1;
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 16'h0005; reqWdata = 32'h0BADF00D;
      begin
         int n;
         n = 0;
         while (selRespValid !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
         checkOutput("bpLatency", 32'(n), 32'd3);
      end
      for (int i = 0; i < 5; i++) begin
         checkOutput("bpValid", 32'(selRespValid), 32'd1);
         checkOutput("bpRdata", selRdata, 32'h12345678);
         checkOutput("bpReqReady", 32'(selReqReady), 32'd0);
         if (i < 4) begin @(posedge clk); #1; end
      end
      respReady = 1'b1;
      @(posedge clk); #1;
      respReady = 1'b0;
      checkIdleOutputs("bpReturn");
      @(posedge clk); #1;
      reqValid = 1'b0;
      checkOutput("bpHeldAccepted", 32'(selBusy), 32'd1);
      checkOutput("bpHeldReady", 32'(selReqReady), 32'd0);
      repeat (3) @(posedge clk); #1;
      checkOutput("bpHeldResp", 32'(selRespValid), 32'd1);
      respReady = 1'b1;
      @(posedge clk); #1;
      respReady = 1'b0;
      modelApply(0, 1, 16'h0005, 32'h0BADF00D);
      applyStimulus(0, 0, 16'h0005, 32'h0, 0, rd, er);
      checkOutput("bpHeldStore", rd, 32'h0BADF00D);

      // Reset two cycles into the wait phase aborts the store.
      sel = 2; reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 16'h0020; reqWdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      reqValid = 1'b0;
      repeat (2) @(posedge clk); #1;
      applyReset();
      checkIdleOutputs("midWaitReset");
      applyStimulus(2, 0, 16'h0020, 32'h0, 0, rd, er);
      checkOutput("midWaitNoWrite", rd, 32'hAAAA5555);

      // Reset on the commit edge itself: still no write.
      sel = 2; reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 16'h0020; reqWdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      reqValid = 1'b0;
      repeat (4) @(posedge clk); #1;
      applyReset();
      checkIdleOutputs("commitReset");
      applyStimulus(2, 0, 16'h0020, 32'h0, 0, rd, er);
      checkOutput("commitNoWrite", rd, 32'hAAAA5555);

      // Random traffic against the word-level model.
      for (int t = 0; t < 80; t++) begin
         int          s, hold, key;
         bit          wr, known;
         logic [15:0] a;
         logic [31:0] d, expRd;
         logic        expErr;
         s = $urandom_range(0, 2);
         wr = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 7) == 0) ? 16'(32'h2000 + $urandom_range(0, 63))
                                         : 16'($urandom_range(0, 63));
         d = $urandom;
         hold = $urandom_range(0, 3);
         key = keyOf(s, a);
         expErr = modelErr(a);
         known = wr || expErr || refMem.exists(key);
         expRd = (wr || expErr || !refMem.exists(key)) ? 32'h0 : refMem[key];
         applyStimulus(s, wr, a, d, hold, rd, er);
         checkOutput("rndErr", 32'(er), 32'(expErr));
         if (known) checkOutput("rndRdata", rd, expRd);
         modelApply(s, wr, a, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
